// File: rtl/mult_pkg.sv
// Shared constants, FSM state type and column-truncation helper for the
// bit-serial shift-add multiplier back end.
package mult_pkg;

   localparam int WIDTH  = 16;
   localparam int PROD_W = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Clears product columns [trunc-1:0]; trunc >= PROD_W clears everything.
   function automatic logic [PROD_W-1:0] mask(input logic [PROD_W-1:0] x,
                                              input int unsigned   trunc);
      logic [PROD_W-1:0] keep;
      keep = '1;
      keep = keep << trunc;
      return x & keep;
   endfunction

endpackage

// File: rtl/shift_add_accumulator_if.sv
// Request/result bundle between the multiplier front end and the
// shift-add accumulator.
interface shift_add_accumulator_if #(
   parameter int WIDTH = mult_pkg::WIDTH
);
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               ready;
   logic               done;
   logic [2*WIDTH-1:0] product;

   modport master (
      output start, a, b,
      input  ready, done, product
   );

   modport slave (
      input  start, a, b,
      output ready, done, product
   );
endinterface

// File: rtl/pp_row_reg.sv
// Registered partial-product row: operand ANDed with one multiplier bit,
// loaded when en is high, cleared synchronously by rst_n.
module pp_row_reg #(
   parameter int WIDTH = mult_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] operand,
   input  logic             mbit,
   output logic [WIDTH-1:0] row
);
   logic [WIDTH-1:0] and_row;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_and
         assign and_row[gi] = operand[gi] & mbit;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row <= '0;
      end else if (en) begin
         row <= and_row;
      end
   end
endmodule

// File: rtl/shift_add_accumulator.sv
// Bit-serial unsigned multiplier back end: one partial-product row per cycle,
// accumulated shifted (optionally low-column truncated) into a 2*WIDTH product.
module shift_add_accumulator #(
   parameter int WIDTH = mult_pkg::WIDTH,
   parameter int TRUNC = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   shift_add_accumulator_if.slave  bus
);
   import mult_pkg::*;

   localparam int CW = $clog2(WIDTH);
   localparam int PW = 2 * WIDTH;

   state_t            state_reg;
   state_t            state_next;
   logic [WIDTH-1:0]  a_reg;
   logic [WIDTH-1:0]  b_reg;
   logic [CW-1:0]     count_reg;
   logic [CW-1:0]     row_idx_reg;
   logic [PW-1:0]     acc_reg;
   logic [PW-1:0]     product_reg;
   logic              done_reg;

   logic [WIDTH-1:0]  row;
   logic              row_en;
   logic              accept;
   logic [PW-1:0]     shifted;
   logic [PW-1:0]     addend;
   logic [PW-1:0]     sum;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      row_en     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            row_en = 1'b1;
            if (count_reg == CW'(WIDTH - 1)) begin
               state_next = DRAIN;
            end
         end
         DRAIN:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   pp_row_reg #(
      .WIDTH (WIDTH)
   ) u_row (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (row_en),
      .operand (a_reg),
      .mbit    (b_reg[count_reg]),
      .row     (row)
   );

   // The row registered last cycle is weighted by the bit index it came from.
   always_comb begin
      shifted = PW'(row);
      shifted = shifted << row_idx_reg;
      addend  = PW'(mask(PROD_W'(shifted), TRUNC));
      sum     = acc_reg + addend;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg       <= '0;
         b_reg       <= '0;
         count_reg   <= '0;
         row_idx_reg <= '0;
         acc_reg     <= '0;
         product_reg <= '0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  a_reg     <= bus.a;
                  b_reg     <= bus.b;
                  count_reg <= '0;
                  acc_reg   <= '0;
               end
            end
            RUN: begin
               row_idx_reg <= count_reg;
               count_reg   <= count_reg + 1'b1;
               // No row is registered yet on the first RUN cycle.
               if (count_reg != '0) begin
                  acc_reg <= sum;
               end
            end
            DRAIN: begin
               product_reg <= sum;
               done_reg    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.ready   = (state_reg == IDLE);
   assign bus.done    = done_reg;
   assign bus.product = product_reg;
endmodule

// File: tb/tb_shift_add_accumulator.sv
// Bench: three accumulators (TRUNC 0/4/8) share one stimulus stream and are
// checked against an arithmetic reference of the truncated shift-add sum.
module tb_shift_add_accumulator;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   shift_add_accumulator_if #(.WIDTH(16)) if0 ();
   shift_add_accumulator_if #(.WIDTH(16)) if1 ();
   shift_add_accumulator_if #(.WIDTH(16)) if2 ();

   assign if0.start = start;
   assign if0.a     = a;
   assign if0.b     = b;
   assign if1.start = start;
   assign if1.a     = a;
   assign if1.b     = b;
   assign if2.start = start;
   assign if2.a     = a;
   assign if2.b     = b;

   shift_add_accumulator #(.WIDTH(16), .TRUNC(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   shift_add_accumulator #(.WIDTH(16), .TRUNC(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   shift_add_accumulator #(.WIDTH(16), .TRUNC(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y,
                                            input int t);
      longint s = 0;
      for (int i = 0; i < 16; i++) begin
         if (y[i]) s += ((longint'(x) << i) >> t) << t;
      end
      return 32'(s);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller has start=1 with operands applied in a ready cycle. Returns in the
   // done cycle. poke>=0 pulses start with junk operands at lat==poke and lat==16.
   task automatic do_op(input int poke, output logic [31:0] p0, output logic [31:0] p1,
                        output logic [31:0] p2, output int lat, output bit ready_hi);
      lat      = 0;
      ready_hi = 1'b0;
      tick();
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
      while (!if0.done && lat < 40) begin
         if (if0.ready) ready_hi = 1'b1;
         if (poke >= 0 && (lat == poke || lat == 16)) begin
            start = 1'b1;
            a     = 16'($urandom);
            b     = 16'($urandom);
         end else begin
            start = 1'b0;
         end
         tick();
         lat++;
      end
      start = 1'b0;
      if (lat >= 40) begin
         checks++;
         failures++;
         $display("FAIL op_timeout: no done within %0d cycles (required 17)", lat);
      end
      p0 = if0.product;
      p1 = if1.product;
      p2 = if2.product;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) tick();
      checks += 4;
      if (if0.ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", if0.ready); end
      if (if0.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", if0.done); end
      if (if0.product !== 32'h0) begin failures++; $display("FAIL reset_product0: got %h want 0", if0.product); end
      if (if2.product !== 32'h0) begin failures++; $display("FAIL reset_product2: got %h want 0", if2.product); end
      rst_n = 1'b1;
      tick();
      $display("tx reset ready=%b done=%b product=%h", if0.ready, if0.done, if0.product);
   endtask

   task automatic test_directed();
      logic [15:0] ta [4] = '{16'h0003, 16'hFFFF, 16'h00FF, 16'h1234};
      logic [15:0] tb [4] = '{16'h0003, 16'hFFFF, 16'h0001, 16'h0000};
      logic [31:0] te [4] = '{32'h0000_0009, 32'hFFFE_0001, 32'h0000_00FF, 32'h0000_0000};
      logic [31:0] p0, p1, p2;
      int lat;
      bit rh;
      for (int k = 0; k < 4; k++) begin
         start = 1'b1;
         a     = ta[k];
         b     = tb[k];
         do_op(-1, p0, p1, p2, lat, rh);
         $display("tx directed a=%h b=%h p0=%h p1=%h p2=%h lat=%0d", ta[k], tb[k], p0, p1, p2, lat);
         checks += 6;
         if (lat !== 17) begin failures++; $display("FAIL dir_latency: got %0d want 17", lat); end
         if (rh !== 1'b0) begin failures++; $display("FAIL dir_ready_low: ready seen high during op, want low"); end
         if (if0.ready !== 1'b1) begin failures++; $display("FAIL dir_ready_done: got %b want 1", if0.ready); end
         if (p0 !== te[k]) begin failures++; $display("FAIL dir_p0: got %h want %h", p0, te[k]); end
         if (p1 !== ref_prod(ta[k], tb[k], 4)) begin failures++; $display("FAIL dir_p1: got %h want %h", p1, ref_prod(ta[k], tb[k], 4)); end
         if (p2 !== ref_prod(ta[k], tb[k], 8)) begin failures++; $display("FAIL dir_p2: got %h want %h", p2, ref_prod(ta[k], tb[k], 8)); end
         if (k == 2) begin
            checks++;
            if (p1 !== 32'h0000_00F0) begin failures++; $display("FAIL dir_trunc4: got %h want 000000f0", p1); end
         end
         tick();
         checks++;
         if (if0.done !== 1'b0) begin failures++; $display("FAIL dir_done_pulse: got %b want 0", if0.done); end
      end
   endtask

   task automatic test_ignored_start();
      logic [15:0] sa, sb;
      logic [31:0] p0, p1, p2;
      int lat;
      bit rh;
      sa    = 16'($urandom);
      sb    = 16'($urandom);
      start = 1'b1;
      a     = sa;
      b     = sb;
      do_op(3, p0, p1, p2, lat, rh);
      $display("tx ignored_start a=%h b=%h p0=%h p1=%h p2=%h lat=%0d", sa, sb, p0, p1, p2, lat);
      checks += 4;
      if (lat !== 17) begin failures++; $display("FAIL ign_latency: got %0d want 17", lat); end
      if (p0 !== ref_prod(sa, sb, 0)) begin failures++; $display("FAIL ign_p0: got %h want %h", p0, ref_prod(sa, sb, 0)); end
      if (p1 !== ref_prod(sa, sb, 4)) begin failures++; $display("FAIL ign_p1: got %h want %h", p1, ref_prod(sa, sb, 4)); end
      if (p2 !== ref_prod(sa, sb, 8)) begin failures++; $display("FAIL ign_p2: got %h want %h", p2, ref_prod(sa, sb, 8)); end
      tick();
      checks++;
      if (if0.ready !== 1'b1) begin failures++; $display("FAIL ign_idle: ready got %b want 1", if0.ready); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] xa [2];
      logic [15:0] xb [2];
      logic [31:0] p0, p1, p2;
      int lat;
      bit rh;
      for (int k = 0; k < 2; k++) begin
         xa[k] = 16'($urandom);
         xb[k] = 16'($urandom);
      end
      start = 1'b1;
      a     = xa[0];
      b     = xb[0];
      for (int k = 0; k < 2; k++) begin
         do_op(-1, p0, p1, p2, lat, rh);
         $display("tx back_to_back%0d a=%h b=%h p0=%h p1=%h p2=%h lat=%0d", k, xa[k], xb[k], p0, p1, p2, lat);
         checks += 4;
         if (lat !== 17) begin failures++; $display("FAIL b2b_latency: got %0d want 17", lat); end
         if (p0 !== ref_prod(xa[k], xb[k], 0)) begin failures++; $display("FAIL b2b_p0: got %h want %h", p0, ref_prod(xa[k], xb[k], 0)); end
         if (p1 !== ref_prod(xa[k], xb[k], 4)) begin failures++; $display("FAIL b2b_p1: got %h want %h", p1, ref_prod(xa[k], xb[k], 4)); end
         if (p2 !== ref_prod(xa[k], xb[k], 8)) begin failures++; $display("FAIL b2b_p2: got %h want %h", p2, ref_prod(xa[k], xb[k], 8)); end
         if (k == 0) begin
            start = 1'b1;
            a     = xa[1];
            b     = xb[1];
         end
      end
   endtask

   task automatic test_abort();
      logic [15:0] sa, sb;
      logic [31:0] p0, p1, p2;
      int lat;
      bit rh;
      bit saw_done;
      start = 1'b1;
      a     = 16'hBEEF;
      b     = 16'hFFFF;
      tick();
      start = 1'b0;
      repeat (7) tick();
      rst_n = 1'b0;
      tick();
      $display("tx abort ready=%b done=%b product=%h", if0.ready, if0.done, if0.product);
      checks += 4;
      if (if0.ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b want 1", if0.ready); end
      if (if0.done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b want 0", if0.done); end
      if (if0.product !== 32'h0) begin failures++; $display("FAIL abort_product0: got %h want 0", if0.product); end
      if (if1.product !== 32'h0) begin failures++; $display("FAIL abort_product1: got %h want 0", if1.product); end
      rst_n    = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (if0.done) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_no_done: done seen after abort, want none"); end
      sa    = 16'($urandom);
      sb    = 16'($urandom);
      start = 1'b1;
      a     = sa;
      b     = sb;
      do_op(-1, p0, p1, p2, lat, rh);
      $display("tx after_abort a=%h b=%h p0=%h p1=%h p2=%h lat=%0d", sa, sb, p0, p1, p2, lat);
      checks += 2;
      if (p0 !== ref_prod(sa, sb, 0)) begin failures++; $display("FAIL abort_next_p0: got %h want %h", p0, ref_prod(sa, sb, 0)); end
      if (p2 !== ref_prod(sa, sb, 8)) begin failures++; $display("FAIL abort_next_p2: got %h want %h", p2, ref_prod(sa, sb, 8)); end
   endtask

   task automatic test_random();
      logic [15:0] sa, sb;
      logic [31:0] p0, p1, p2;
      longint exact;
      int lat;
      bit rh;
      for (int n = 0; n < 1000; n++) begin
         sa = (n % 50 == 0) ? 16'hFFFF : 16'($urandom);
         sb = (n % 37 == 0) ? 16'hFFFF : 16'($urandom);
         exact = longint'(sa) * longint'(sb);
         start = 1'b1;
         a     = sa;
         b     = sb;
         do_op(-1, p0, p1, p2, lat, rh);
         $display("tx random%0d a=%h b=%h p0=%h p1=%h p2=%h lat=%0d", n, sa, sb, p0, p1, p2, lat);
         checks += 6;
         if (lat !== 17) begin failures++; $display("FAIL rnd_latency: got %0d want 17", lat); end
         if (p0 !== ref_prod(sa, sb, 0)) begin failures++; $display("FAIL rnd_p0: got %h want %h", p0, ref_prod(sa, sb, 0)); end
         if (p1 !== ref_prod(sa, sb, 4)) begin failures++; $display("FAIL rnd_p1: got %h want %h", p1, ref_prod(sa, sb, 4)); end
         if (p2 !== ref_prod(sa, sb, 8)) begin failures++; $display("FAIL rnd_p2: got %h want %h", p2, ref_prod(sa, sb, 8)); end
         if (longint'(p1) > exact) begin failures++; $display("FAIL rnd_bound1: got %h exceeds exact %h", p1, exact); end
         if (longint'(p2) > exact) begin failures++; $display("FAIL rnd_bound2: got %h exceeds exact %h", p2, exact); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      test_reset();
      test_directed();
      test_ignored_start();
      test_back_to_back();
      test_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
